// File: rtl/alu_seq.sv
// alu_seq: registered, parametrised ALU with a multi-cycle shift-add multiply.
//
// Accepts two WIDTH-bit operands and a 3-bit opcode on a start strobe.
// It returns a 2*WIDTH-bit registered result with a one-cycle done pulse.
// Single-cycle ops complete on the sampling edge.
// Opcode 110 (unsigned multiply) runs for WIDTH cycles with busy high.
//
// Configuration macro: ALU_SEQ_MUL_EN
//   defined   - opcode 110 runs the WIDTH-cycle shift-add multiply
//   undefined - no multiply datapath; opcode 110 loads result = 0 in one
//               cycle and busy is tied low
//
// Ports:
//   clk      in   1        system clock, rising edge
//   reset_n  in   1        asynchronous active-low reset
//   start    in   1        request, sampled only while busy = 0
//   op       in   3        opcode, sampled with start
//   a        in   WIDTH    operand A, sampled with start
//   b        in   WIDTH    operand B, sampled with start
//   busy     out  1        high while a multiply is in progress
//   done     out  1        one-cycle pulse when result is updated
//   result   out  2*WIDTH  registered result, held between operations

module alu_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned RW = 2 * WIDTH;

    localparam logic [2:0] OP_INC  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_ACC  = 3'b010;
    localparam logic [2:0] OP_BIT  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_CAT  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    logic [RW-1:0] r_result;
    logic          r_done;
    logic [RW-1:0] w_single;

    // Result of every single-cycle opcode.
    // The accumulate op reads the pre-edge result.
    always_comb begin
        w_single = '0;
        case (op)
            OP_INC:  w_single = RW'(a) + RW'(1);
            OP_ADD:  w_single = RW'(a) + RW'(b);
            OP_ACC:  w_single = r_result + RW'(a);
            OP_BIT:  w_single = {a | b, a ^ b};
            OP_ROR:  w_single = RW'(|{a, b});
            OP_CAT:  w_single = {b, a};
            OP_MUL:  w_single = '0;
            OP_CLR:  w_single = '0;
            default: w_single = '0;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t              r_state;
    logic                r_busy;
    logic [WIDTH-1:0]    r_mcand;
    logic [WIDTH-1:0]    r_mplier;
    logic [RW-1:0]       r_prod;
    logic [CNT_W-1:0]    r_cnt;

    logic [RW-1:0]       w_partial;
    logic [RW-1:0]       w_prod_next;

    // One shift-add step: the multiplicand is weighted by the iteration count
    // rather than shifted in place, so it can stay a WIDTH-bit register.
    assign w_partial   = r_mplier[0] ? (RW'(r_mcand) << r_cnt) : '0;
    assign w_prod_next = r_prod + w_partial;

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (op == OP_MUL) begin
                            r_mcand  <= a;
                            r_mplier <= b;
                            r_prod   <= '0;
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= S_MUL;
                        end else begin
                            r_result <= w_single;
                            r_done   <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_prod   <= w_prod_next;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    // The last step publishes the product including its own addend.
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_result <= w_prod_next;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;

`else

    // Without the multiplier every opcode completes in a single cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_result <= w_single;
                r_done   <= 1'b1;
            end
        end
    end

    assign busy = 1'b0;

`endif

    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH = 4).
// Expected results go into a queue when a request is driven.
// Entries are popped when done is seen.

module tb_alu_seq;

    localparam int unsigned W  = 4;
    localparam int unsigned RW = 2 * W;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [RW-1:0] result;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [RW-1:0] sb_q[$];
    logic [RW-1:0] m_res;
    logic          got_done;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample #1 later.
    // A done pulse must match the oldest queued expectation.
    task automatic cycle();
        logic [RW-1:0] e;
        @(posedge clk);
        #1;
        got_done = done;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("spurious_done", RW'(done), RW'(0));
            end else begin
                e = sb_q.pop_front();
                chk("sb_result", result, e);
            end
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [RW-1:0] e);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        sb_q.push_back(e);
        m_res = e;
        cycle();
        chk("done_single", RW'(got_done), RW'(1));
    endtask

    task automatic idle();
        start = 1'b0;
        cycle();
    endtask

    function automatic logic [RW-1:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                            input logic [W-1:0] y, input logic [RW-1:0] prev);
        logic [RW-1:0] r;
        case (o)
            3'b000:  r = {4'h0, x} + 8'd1;
            3'b001:  r = {4'h0, x} + {4'h0, y};
            3'b010:  r = prev + {4'h0, x};
            3'b011:  r = {x | y, x ^ y};
            3'b100:  r = ((x != 4'h0) || (y != 4'h0)) ? 8'h01 : 8'h00;
            3'b101:  r = {y, x};
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    initial begin
        logic [2:0]    ro;
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;
        logic [RW-1:0] re;

        reset_n = 1'b0;
        start   = 1'b0;
        op      = 3'b000;
        a       = '0;
        b       = '0;
        m_res   = '0;
        #12;
        chk("reset_result", result, 8'h00);
        chk("reset_done", RW'(done), RW'(0));
        chk("reset_busy", RW'(busy), RW'(0));
        @(negedge clk);
        reset_n = 1'b1;
        cycle();

        // Single-cycle ops with a carry out of the low half.
        issue(3'b001, 4'hF, 4'h1, 8'h10);
        chk("add_carry", result, 8'h10);
        idle();
        chk("done_pulse_low", RW'(done), RW'(0));
        issue(3'b000, 4'hF, 4'h0, 8'h10);
        chk("inc_carry", result, 8'h10);
        idle();

        // Bitwise ops, issued back-to-back.
        issue(3'b011, 4'hA, 4'h6, 8'hEC);
        chk("or_xor", result, 8'hEC);
        issue(3'b101, 4'h3, 4'hC, 8'hC3);
        chk("concat", result, 8'hC3);
        issue(3'b100, 4'h0, 4'h0, 8'h00);
        chk("redor_zero", result, 8'h00);
        issue(3'b100, 4'h0, 4'h8, 8'h01);
        chk("redor_one", result, 8'h01);
        idle();
        chk("hold_result", result, 8'h01);

        // Accumulate wrap with start held high throughout.
        issue(3'b111, 4'h0, 4'h0, 8'h00);
        for (int i = 0; i < 17; i++) begin
            issue(3'b010, 4'hF, 4'h0, m_res + 8'h0F);
        end
        chk("acc_ff", result, 8'hFF);
        issue(3'b010, 4'h1, 4'h0, 8'h00);
        chk("acc_wrap", result, 8'h00);
        idle();

        // Short random run of single-cycle ops against the model.
        for (int i = 0; i < 10; i++) begin
            ro = 3'($urandom_range(0, 7));
            if (ro == 3'b110) ro = 3'b010;
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            re = model(ro, ra, rb, m_res);
            issue(ro, ra, rb, re);
        end
        idle();

`ifdef ALU_SEQ_MUL_EN
        // Multiply F*F; operands toggled and start re-pulsed while busy.
        start = 1'b1; op = 3'b110; a = 4'hF; b = 4'hF;
        sb_q.push_back(8'hE1);
        cycle();
        chk("mul_busy0", RW'(busy), RW'(1));
        chk("mul_nodone0", RW'(got_done), RW'(0));
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            op    = 3'($urandom_range(0, 7));
            a     = 4'($urandom_range(0, 15));
            b     = 4'($urandom_range(0, 15));
            cycle();
            chk("mul_busy", RW'(busy), RW'(1));
            chk("mul_nodone", RW'(got_done), RW'(0));
        end
        start = 1'b1; op = 3'b001; a = 4'h2; b = 4'h3;
        cycle();
        chk("mul_done", RW'(got_done), RW'(1));
        chk("mul_busy_clr", RW'(busy), RW'(0));
        chk("mul_ff", result, 8'hE1);
        // The held start is accepted on the edge after done.
        sb_q.push_back(8'h05);
        cycle();
        chk("after_mul_accept", RW'(got_done), RW'(1));
        chk("after_mul_result", result, 8'h05);
        idle();

        // Random multiplies.
        for (int i = 0; i < 4; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            start = 1'b1; op = 3'b110; a = ra; b = rb;
            sb_q.push_back(8'(ra) * 8'(rb));
            cycle();
            start = 1'b0;
            repeat (3) cycle();
            chk("rmul_nodone_early", RW'(got_done), RW'(0));
            cycle();
            chk("rmul_done", RW'(got_done), RW'(1));
        end
        idle();

        // Reset in the middle of a multiply.
        issue(3'b101, 4'hA, 4'h5, 8'h5A);
        chk("pre_reset", result, 8'h5A);
        start = 1'b1; op = 3'b110; a = 4'h3; b = 4'h3;
        sb_q.push_back(8'h09);
        cycle();
        start = 1'b0;
        cycle();
        chk("pre_reset_busy", RW'(busy), RW'(1));
`else
        // Opcode 110 collapses to a single-cycle clear.
        issue(3'b101, 4'hA, 4'h5, 8'h5A);
        issue(3'b110, 4'h3, 4'h5, 8'h00);
        chk("mul_off_result", result, 8'h00);
        chk("mul_off_busy", RW'(busy), RW'(0));
        idle();
        issue(3'b101, 4'hA, 4'h5, 8'h5A);
        chk("pre_reset", result, 8'h5A);
        start = 1'b0;
        cycle();
`endif
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_result", result, 8'h00);
        chk("async_rst_busy", RW'(busy), RW'(0));
        chk("async_rst_done", RW'(done), RW'(0));
        sb_q.delete();
        m_res = '0;
        cycle();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) cycle();
        chk("post_rst_result", result, 8'h00);
        chk("post_rst_busy", RW'(busy), RW'(0));

        chk("sb_drain", RW'(sb_q.size()), RW'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
